// File: rtl/cache_pkg.sv
// cache_pkg: types and constants shared by the cache pair and the memory arbiter.
package cache_pkg;

    // Ownership of the single RAM port
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;

    // Block size in words; a grant lasts for this many completed beats
    localparam int ARB_BURST_LEN  = 2;

    // Dcache bursts an icache request may wait through before it is forced in
    localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: CPU-wide shared types.
// ramstate_t is the status code returned by the RAM/memory model each cycle.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/arb_beat_ctr.sv
// arb_beat_ctr: counts completed beats of the current grant and flags the
// cycle on which the burst ends (last beat done, or the owner drops its request).
module arb_beat_ctr
    import cache_pkg::*;
#(
    parameter int BURST_LEN = ARB_BURST_LEN
) (
    input  logic CLK,
    input  logic nRST,
    input  logic granted,
    input  logic beat_done,
    input  logic owner_req,
    output logic burst_end
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [CW-1:0] beat_q;
    logic [CW-1:0] beat_d;
    logic          last_beat;

    // Next beat count and burst-end detection for the current owner
    always_comb begin
        beat_d    = beat_q;
        last_beat = beat_done && (beat_q == LAST_BEAT);
        burst_end = granted && (!owner_req || last_beat);
        if (granted && !owner_req) begin
            beat_d = '0;
        end else if (beat_done) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Beat counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between icache and dcache with
// burst-granular grants, dcache priority and an icache starvation bound.
// Optional MEM_ARBITER_PERF_EN adds icnt/dcnt/scnt performance counters.
module mem_arbiter
    import cache_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int BURST_LEN  = ARB_BURST_LEN,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] icnt,
    output logic [31:0] dcnt,
    output logic [31:0] scnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t    owner_q;
    arb_state_t    owner_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          owner_req;
    logic          granted;
    logic          beat_done;
    logic          burst_end;
    logic          force_igrant;

    // Request of whichever cache currently owns the port, and beat completion
    always_comb begin
        owner_req = 1'b0;
        unique case (owner_q)
            IGNT:    owner_req = iREN;
            DGNT:    owner_req = dREN | dWEN;
            default: owner_req = 1'b0;
        endcase
        granted   = (owner_q != IDLE);
        beat_done = owner_req && (ramstate == ACCESS);
    end

    arb_beat_ctr #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_ctr (
        .CLK       (CLK),
        .nRST      (nRST),
        .granted   (granted),
        .beat_done (beat_done),
        .owner_req (owner_req),
        .burst_end (burst_end)
    );

    // Arbitration in IDLE, release on burst end, starvation bookkeeping
    always_comb begin
        owner_d      = owner_q;
        starve_d     = starve_q;
        force_igrant = 1'b0;
        unique case (owner_q)
            IDLE: begin
                if (iREN && (starve_q == STARVE_TOP)) begin
                    owner_d      = IGNT;
                    force_igrant = 1'b1;
                end else if (dREN || dWEN) begin
                    owner_d = DGNT;
                end else if (iREN) begin
                    owner_d = IGNT;
                end
            end
            IGNT: begin
                if (burst_end) begin
                    owner_d  = IDLE;
                    starve_d = '0;
                end
            end
            DGNT: begin
                if (burst_end) begin
                    owner_d = IDLE;
                    if (iREN && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            default: owner_d = IDLE;
        endcase
    end

    // Owner and starvation registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner_q  <= IDLE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // RAM routing and per-cache wait/load, decoded from the registered owner
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        unique case (owner_q)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~beat_done;
                iload   = beat_done ? ramload : '0;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~beat_done;
                dload    = beat_done ? ramload : '0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] icnt_q;
    logic [31:0] icnt_d;
    logic [31:0] dcnt_q;
    logic [31:0] dcnt_d;
    logic [31:0] scnt_q;
    logic [31:0] scnt_d;

    // Completed-burst and forced-grant counters, wrapping on overflow
    always_comb begin
        icnt_d = icnt_q;
        dcnt_d = dcnt_q;
        scnt_d = scnt_q;
        if (burst_end && (owner_q == IGNT)) icnt_d = icnt_q + 32'd1;
        if (burst_end && (owner_q == DGNT)) dcnt_d = dcnt_q + 32'd1;
        if (force_igrant)                   scnt_d = scnt_q + 32'd1;
    end

    // Performance counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icnt_q <= '0;
            dcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            dcnt_q <= dcnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign icnt = icnt_q;
    assign dcnt = dcnt_q;
    assign scnt = scnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int BL = 2;
    localparam int SM = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] icnt;
    logic [31:0] dcnt;
    logic [31:0] scnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: who holds the port (0 nobody, 1 icache, 2 dcache), beats done in
    // this burst, dcache bursts the icache has sat through, beat done this cycle
    int m_owner;
    int m_beats;
    int m_starve;
    bit m_done;

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .icnt     (icnt),
        .dcnt     (dcnt),
        .scnt     (scnt)
`endif
    );

    // Free-running 10-unit clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic i_ren, input logic [31:0] i_addr,
                                 input logic d_ren, input logic d_wen,
                                 input logic [31:0] d_addr, input logic [31:0] d_store,
                                 input logic [1:0] rs, input logic [31:0] rl);
        iREN     = i_ren;
        iaddr    = i_addr;
        dREN     = d_ren;
        dWEN     = d_wen;
        daddr    = d_addr;
        dstore   = d_store;
        ramstate = rs;
        ramload  = rl;
    endtask

    // Predict every output from the model's owner and the current inputs
    task automatic modelCheck();
        logic        e_rren, e_rwen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        e_rren = 0; e_rwen = 0; e_addr = 0; e_store = 0;
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
        m_done = 0;
        if (m_owner == 1) begin
            e_rren = iREN;
            e_addr = iaddr;
            m_done = iREN && (ramstate == ACCESS);
            if (m_done) begin
                e_iwait = 0;
                e_iload = ramload;
            end
        end else if (m_owner == 2) begin
            e_rwen  = dWEN;
            e_rren  = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            m_done  = (dREN || dWEN) && (ramstate == ACCESS);
            if (m_done) begin
                e_dwait = 0;
                e_dload = ramload;
            end
        end
        checkOutput("ramREN",   ramREN,   e_rren);
        checkOutput("ramWEN",   ramWEN,   e_rwen);
        checkOutput("ramaddr",  ramaddr,  e_addr);
        checkOutput("ramstore", ramstore, e_store);
        checkOutput("iwait",    iwait,    e_iwait);
        checkOutput("iload",    iload,    e_iload);
        checkOutput("dwait",    dwait,    e_dwait);
        checkOutput("dload",    dload,    e_dload);
    endtask

    // Apply the grant/burst rules at a clock edge
    task automatic modelAdvance();
        bit req;
        bit ended;
        if (m_owner == 0) begin
            if (iREN && m_starve == SM)  m_owner = 1;
            else if (dREN || dWEN)       m_owner = 2;
            else if (iREN)               m_owner = 1;
        end else begin
            req   = (m_owner == 1) ? iREN : (dREN || dWEN);
            ended = 0;
            if (!req) begin
                ended   = 1;
                m_beats = 0;
            end else if (m_done) begin
                m_beats++;
                if (m_beats == BL) begin
                    ended   = 1;
                    m_beats = 0;
                end
            end
            if (ended) begin
                if (m_owner == 2 && iREN && m_starve < SM) m_starve++;
                if (m_owner == 1) m_starve = 0;
                m_owner = 0;
            end
        end
    endtask

    task automatic stepCheck();
        @(negedge CLK);
        modelCheck();
    endtask

    task automatic stepAdvance();
        @(posedge CLK);
        modelAdvance();
        #1;
    endtask

    task automatic cycle();
        stepCheck();
        stepAdvance();
    endtask

    // Asynchronous reset: outputs must fall to reset values without a clock edge
    task automatic doReset();
        nRST = 1'b0;
        #1;
        checkOutput("rst_ramREN",   ramREN,   0);
        checkOutput("rst_ramWEN",   ramWEN,   0);
        checkOutput("rst_ramaddr",  ramaddr,  0);
        checkOutput("rst_ramstore", ramstore, 0);
        checkOutput("rst_iwait",    iwait,    1);
        checkOutput("rst_dwait",    dwait,    1);
        checkOutput("rst_iload",    iload,    0);
        checkOutput("rst_dload",    dload,    0);
`ifdef MEM_ARBITER_PERF_EN
        checkOutput("rst_dcnt", dcnt, 0);
        checkOutput("rst_icnt", icnt, 0);
        checkOutput("rst_scnt", scnt, 0);
`endif
        m_owner = 0; m_beats = 0; m_starve = 0; m_done = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        modelAdvance();
        #1;
    endtask

    // Directed scenarios, then random traffic
    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        doReset();

        // Icache alone: two BUSY cycles, then a beat returning 0xDEAD
        applyStimulus(1, 32'h100, 0, 0, 0, 0, BUSY, 0);
        stepCheck(); checkOutput("ic_idle_ramREN", ramREN, 0); stepAdvance();
        cycle();
        cycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, ACCESS, 32'hDEAD);
        stepCheck();
        checkOutput("ic_beat_iwait", iwait, 0);
        checkOutput("ic_beat_iload", iload, 32'hDEAD);
        checkOutput("ic_beat_dwait", dwait, 1);
        stepAdvance();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, ACCESS, 32'hBEEF);
        cycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, BUSY, 0);
        stepCheck(); checkOutput("ic_gap_ramREN", ramREN, 0); stepAdvance();
        stepCheck();
        checkOutput("ic_regrant_ramREN", ramREN, 1);
        checkOutput("ic_regrant_ramaddr", ramaddr, 32'h100);
        stepAdvance();

        // Simultaneous requests: dcache wins, icache follows
        doReset();
        applyStimulus(1, 32'h180, 1, 0, 32'h200, 0, ACCESS, 32'h1111);
        cycle();
        stepCheck();
        checkOutput("sim_beat0_ramaddr", ramaddr, 32'h200);
        checkOutput("sim_beat0_iwait", iwait, 1);
        stepAdvance();
        applyStimulus(1, 32'h180, 1, 0, 32'h204, 0, ACCESS, 32'h2222);
        stepCheck();
        checkOutput("sim_beat1_ramaddr", ramaddr, 32'h204);
        checkOutput("sim_beat1_dload", dload, 32'h2222);
        checkOutput("sim_beat1_iwait", iwait, 1);
        stepAdvance();
        applyStimulus(1, 32'h180, 0, 0, 0, 0, BUSY, 0);
        cycle();
        stepCheck();
        checkOutput("sim_igrant_ramREN", ramREN, 1);
        checkOutput("sim_igrant_ramaddr", ramaddr, 32'h180);
        stepAdvance();

        // Starvation: four dcache bursts, then a forced icache grant
        doReset();
        applyStimulus(1, 32'h300, 0, 1, 32'h400, 32'h9, ACCESS, 32'h77);
        for (int cyc = 0; cyc < 17; cyc++) begin
            stepCheck();
            if (cyc == 13) begin
                checkOutput("starve_igrant_iwait", iwait, 0);
                checkOutput("starve_igrant_ramaddr", ramaddr, 32'h300);
                checkOutput("starve_igrant_dwait", dwait, 1);
            end
            if (cyc == 16) begin
                checkOutput("starve_cleared_ramWEN", ramWEN, 1);
                checkOutput("starve_cleared_iwait", iwait, 1);
            end
            stepAdvance();
        end

        // Read and write together: the write wins
        doReset();
        applyStimulus(0, 0, 1, 1, 32'h600, 32'h55, BUSY, 0);
        cycle();
        stepCheck();
        checkOutput("rw_ramWEN", ramWEN, 1);
        checkOutput("rw_ramREN", ramREN, 0);
        checkOutput("rw_ramstore", ramstore, 32'h55);
        stepAdvance();

        // Owner drops after one beat, then ERROR stalls a fresh burst
        applyStimulus(0, 0, 1, 0, 32'h600, 0, ACCESS, 32'hA1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, ACCESS, 0);
        cycle();
        applyStimulus(0, 0, 1, 0, 32'h700, 0, ERROR, 32'hA2);
        stepCheck(); checkOutput("drop_idle_ramREN", ramREN, 0); stepAdvance();
        for (int k = 0; k < 3; k++) begin
            stepCheck();
            checkOutput("err_dwait", dwait, 1);
            stepAdvance();
        end
        applyStimulus(0, 0, 1, 0, 32'h700, 0, ACCESS, 32'hA3);
        cycle();
        stepCheck();
        checkOutput("err_second_beat_dwait", dwait, 0);
        stepAdvance();
        stepCheck(); checkOutput("err_burst_done_ramREN", ramREN, 0); stepAdvance();

        // Reset in the middle of a dcache burst
        doReset();
        applyStimulus(0, 0, 1, 0, 32'h500, 0, BUSY, 0);
        cycle();
        stepCheck(); checkOutput("mid_dgnt_ramREN", ramREN, 1); stepAdvance();
        doReset();
        applyStimulus(0, 0, 1, 0, 32'h500, 0, BUSY, 0);
        stepCheck(); checkOutput("mid_after_rst_ramREN", ramREN, 0); stepAdvance();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 5,
                          $urandom_range(0, 9) < 3, $urandom, $urandom,
                          2'($urandom_range(0, 3)), $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache and the data cache of one core.
- Grants are burst-granular: an owner keeps the port for a full block transfer of BURST_LEN word beats, so a 2-word dcache fill or writeback is never split by an ifetch.
- Dcache has priority; an icache starvation counter bounds ifetch latency.
- Sits between the cache pair and the RAM/memory model; owns RAM request routing and the per-cache wait signals.

Parameters:
- BURST_LEN, 2, beats per granted burst (block size in words).
- STARVE_MAX, 4, consecutive dcache bursts granted while icache waits before icache is forced to win.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; low for exactly one cycle per completed icache beat
- iload  out  32  icache read data, valid when iwait low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; low for exactly one cycle per completed dcache beat
- dload  out  32  dcache read data, valid when dwait low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset values: owner register = NONE, beat counter = 0, starve counter = 0. All RAM outputs are 0; iwait = dwait = 1; iload = dload = 0.
- States:
  - IDLE: no owner.
  - IGNT: icache owns the port.
  - DGNT: dcache owns the port.
- Owner register, beat counter and starve counter are registered. RAM and cache outputs are combinational from the registered owner.
- IDLE arbitration (evaluated every cycle):
  - Icache wins if iREN and starve counter == STARVE_MAX.
  - Otherwise dcache wins if dREN|dWEN.
  - Otherwise icache wins if iREN.
  - Otherwise stay in IDLE.
  - The grant takes effect the next cycle. No RAM request is driven while in IDLE.
- IGNT: ramREN = iREN, ramaddr = iaddr; ramWEN = 0, ramstore = 0.
- DGNT:
  - ramaddr = daddr, ramstore = dstore.
  - ramWEN = dWEN. ramREN = dREN & ~dWEN: if both are asserted, the write wins and only ramWEN is driven.
- Beat completion is ramstate == ACCESS while the owner's request is high.
  - The owner's wait goes low that cycle; the owner's load = ramload.
  - The non-owner's wait stays 1 and its load stays 0.
  - Beat counter increments on completion.
- A burst ends on either of:
  - the BURST_LEN-th beat completing, in which case the beat counter wraps to 0;
  - the owner deasserting all request lines, in which case the beat counter clears to 0.
  
  On burst end, return to IDLE; re-arbitration happens in IDLE on the following cycle. Back-to-back bursts therefore have 1 idle cycle.
- Starve counter:
  - On a DGNT burst end with iREN high: saturating increment, max STARVE_MAX.
  - On an IGNT burst end: clear to 0.
  - Otherwise: hold.
- ramstate BUSY, FREE or ERROR during a grant: the owner's wait stays 1 and nothing advances. ERROR is treated like BUSY.
- Requests not seen in IDLE are not latched; requesters must hold request until their wait is low.
- Reset mid-burst: everything returns to reset values immediately (asynchronous). The partial burst is abandoned.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- When defined:
  - adds outputs icnt and dcnt, 32 bits each, counting completed bursts per requester, and scnt, 32 bits, counting forced starvation grants;
  - all three reset to 0 and wrap on overflow.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- cache_pkg gains:
  - arb_state_t (IDLE, IGNT, DGNT);
  - constant ARB_BURST_LEN = 2.
- ramstate_t stays in cpu_types_pkg.
- One natural sub-module: arb_beat_ctr. It holds the beat counter plus burst-end detection. Inputs: beat-done, owner-request, BURST_LEN. Output: burst_end pulse.

Test Plan:
- Icache only: iREN held, iaddr 0x100, RAM gives ACCESS after 2 BUSY cycles, ramload 0xDEAD -> iwait low 1 cycle with iload 0xDEAD; dwait stays 1; icache is regranted after 1 IDLE cycle.
- Simultaneous iREN and dREN in IDLE -> DGNT. The dcache completes 2 beats at 0x200 and 0x204; iwait stays 1 throughout. Next burst -> IGNT.
- Starvation: dWEN continuously requested with iREN high. After 4 dcache bursts the starve counter = 4 -> the next grant is IGNT even though dWEN is high; the counter is 0 after that icache burst.
- dREN and dWEN both high in DGNT, dstore 0x55 -> ramWEN = 1, ramREN = 0, ramstore 0x55.
- Owner drops request after 1 beat -> return to IDLE with beat counter 0. ramstate ERROR for 3 cycles holds dwait = 1 and the beat count unchanged.
- nRST pulsed low mid-burst during DGNT -> same cycle: ramREN = ramWEN = 0, iwait = dwait = 1, state IDLE. With MEM_ARBITER_PERF_EN defined, dcnt = 0.
